// File: rtl/ysyx_23060061_csr_pkg.sv
// ysyx_23060061_csr_pkg: CSR addresses, op encodings, mstatus fields and op helper
package ysyx_23060061_csr_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  typedef enum logic [1:0] {OP_NONE = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11} csr_op_e;
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int ECALL_CAUSE_DEFAULT = 11;
  function automatic logic [63:0] csr_apply(csr_op_e op, logic [63:0] old, logic [63:0] wd);
    return op == OP_RW ? wd : op == OP_RS ? (old | wd) : op == OP_RC ? (old & ~wd) : old;
  endfunction
endpackage

// File: rtl/ysyx_23060061_csr_counter64.sv
// ysyx_23060061_csr_counter64: 64-bit counter with per-half writes that override increment and carry
module ysyx_23060061_csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_lo_i,
  input  logic [31:0] wdata_hi_i,
  output logic [63:0] cnt_o
);
  logic [31:0] lo_q, lo_d, hi_q, hi_d;
  logic        carry;
  // a written low half never wraps, so it cannot carry
  always_comb begin
    carry = inc_i && !wr_lo_i && (&lo_q);
    lo_d  = wr_lo_i ? wdata_lo_i : lo_q + {31'b0, inc_i};
    hi_d  = wr_hi_i ? wdata_hi_i : hi_q + {31'b0, carry};
  end
  // counter halves
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end
  assign cnt_o = {hi_q, lo_q};
endmodule

// File: rtl/ysyx_23060061_csr_file.sv
// ysyx_23060061_csr_file: M-mode CSR file with trap stacking; counters gated by YSYX_23060061_CSR_COUNTERS_EN
import ysyx_23060061_csr_pkg::*;
module ysyx_23060061_csr_file #(
  parameter int XLEN        = 32,
  parameter int ECALL_CAUSE = ECALL_CAUSE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_en,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            ecall,
  input  logic            mret,
  input  logic            instr_retire,
  input  logic [31:0]     pc,
  output logic [31:0]     redirect_pc,
  output logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mepc
);
  logic            mie_q, mie_d, mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [63:0]     mstatus_v, rd_raw, wval, mcycle, minstret;
  logic            hit, we;
  logic            unused_bits;
`ifdef YSYX_23060061_CSR_COUNTERS_EN
  logic [31:0] whi;
  assign whi = XLEN == 64 ? wval[63:32] : wval[31:0];
  ysyx_23060061_csr_counter64 u_mcycle (
    .clk(clk), .rst(rst), .inc_i(1'b1),
    .wr_lo_i(we && csr_addr == CSR_MCYCLE),
    .wr_hi_i(we && csr_addr == (XLEN == 64 ? CSR_MCYCLE : CSR_MCYCLEH)),
    .wdata_lo_i(wval[31:0]), .wdata_hi_i(whi), .cnt_o(mcycle)
  );
  ysyx_23060061_csr_counter64 u_minstret (
    .clk(clk), .rst(rst), .inc_i(instr_retire),
    .wr_lo_i(we && csr_addr == CSR_MINSTRET),
    .wr_hi_i(we && csr_addr == (XLEN == 64 ? CSR_MINSTRET : CSR_MINSTRETH)),
    .wdata_lo_i(wval[31:0]), .wdata_hi_i(whi), .cnt_o(minstret)
  );
`else
  logic unused_retire;
  assign mcycle        = '0;
  assign minstret      = '0;
  assign unused_retire = instr_retire ^ (^mcycle) ^ (^minstret);
`endif
  // address decode and pre-update read value; the h halves exist only at XLEN=32
  always_comb begin
    mstatus_v = '0;
    mstatus_v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_v[MSTATUS_MIE]  = mie_q;
    mstatus_v[MSTATUS_MPIE] = mpie_q;
    hit    = 1'b1;
    rd_raw = '0;
    case (csr_addr)
      CSR_MSTATUS:   rd_raw = mstatus_v;
      CSR_MTVEC:     rd_raw = 64'(mtvec_q);
      CSR_MSCRATCH:  rd_raw = 64'(mscratch_q);
      CSR_MEPC:      rd_raw = 64'(mepc_q);
      CSR_MCAUSE:    rd_raw = 64'(mcause_q);
`ifdef YSYX_23060061_CSR_COUNTERS_EN
      CSR_MCYCLE:    rd_raw = XLEN == 64 ? mcycle : {32'b0, mcycle[31:0]};
      CSR_MINSTRET:  rd_raw = XLEN == 64 ? minstret : {32'b0, minstret[31:0]};
      CSR_MCYCLEH:   begin hit = XLEN == 32; rd_raw = {32'b0, mcycle[63:32]}; end
      CSR_MINSTRETH: begin hit = XLEN == 32; rd_raw = {32'b0, minstret[63:32]}; end
`endif
      default:       hit = 1'b0;
    endcase
  end
  assign csr_illegal = csr_en && !hit;
  assign csr_rdata   = csr_illegal ? '0 : rd_raw[XLEN-1:0];
  assign we          = csr_en && csr_op != OP_NONE && hit && !ecall && !mret;
  assign wval        = csr_apply(csr_op_e'(csr_op), rd_raw, 64'(csr_wdata));
  assign redirect_pc = ecall ? mtvec_q[31:0] : mepc_q[31:0];
  assign mtvec       = mtvec_q;
  assign mepc        = mepc_q;
  assign unused_bits = ^{pc[1:0], wval};
  // next state: ecall beats mret beats CSR write
  always_comb begin
    mie_d      = ecall ? 1'b0 : mret ? mpie_q : (we && csr_addr == CSR_MSTATUS) ? wval[MSTATUS_MIE] : mie_q;
    mpie_d     = ecall ? mie_q : mret ? 1'b1 : (we && csr_addr == CSR_MSTATUS) ? wval[MSTATUS_MPIE] : mpie_q;
    mtvec_d    = (we && csr_addr == CSR_MTVEC) ? {wval[XLEN-1:2], 2'b00} : mtvec_q;
    mscratch_d = (we && csr_addr == CSR_MSCRATCH) ? wval[XLEN-1:0] : mscratch_q;
    mepc_d     = ecall ? XLEN'({pc[31:2], 2'b00}) : (we && csr_addr == CSR_MEPC) ? {wval[XLEN-1:2], 2'b00} : mepc_q;
    mcause_d   = ecall ? XLEN'(ECALL_CAUSE) : (we && csr_addr == CSR_MCAUSE) ? wval[XLEN-1:0] : mcause_q;
  end
  // architectural CSR registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end
endmodule

// File: tb/tb_ysyx_23060061_csr_file.sv
// tb_ysyx_23060061_csr_file: directed scoreboard bench for the CSR file at XLEN=32
module tb_ysyx_23060061_csr_file;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_en = 1'b0, ecall = 1'b0, mret = 1'b0, instr_retire = 1'b0;
  logic [1:0]  csr_op = 2'b00;
  logic [11:0] csr_addr = 12'h0;
  logic [31:0] csr_wdata = 32'h0, pc = 32'h0;
  logic [31:0] csr_rdata, redirect_pc, mtvec, mepc;
  logic        csr_illegal;
  typedef struct {string tag; int sig; logic [31:0] exp;} sb_t;
  sb_t sb[$];
  int  errs = 0;
  int  checks = 0;
  localparam int S_RD = 0, S_ILL = 1, S_RED = 2, S_MTVEC = 3, S_MEPC = 4;

  always #5 clk = ~clk;

  ysyx_23060061_csr_file #(.XLEN(32), .ECALL_CAUSE(11)) dut (
    .clk(clk), .rst(rst), .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .ecall(ecall), .mret(mret), .instr_retire(instr_retire), .pc(pc),
    .redirect_pc(redirect_pc), .mtvec(mtvec), .mepc(mepc)
  );

  task automatic drive(input logic en, input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                       input logic ec, input logic mr, input logic rt, input logic [31:0] p);
    @(negedge clk);
    rst = 1'b0; csr_en = en; csr_op = op; csr_addr = a; csr_wdata = wd;
    ecall = ec; mret = mr; instr_retire = rt; pc = p;
    #2;
  endtask

  task automatic push(input string tag, input int sig, input logic [31:0] v);
    sb.push_back('{tag, sig, v});
  endtask

  task automatic check;
    sb_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = e.sig == S_RD ? csr_rdata : e.sig == S_ILL ? {31'b0, csr_illegal} :
            e.sig == S_RED ? redirect_pc : e.sig == S_MTVEC ? mtvec : mepc;
      checks++;
      assert (obs === e.exp) else begin
        errs++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] v);
    drive(1'b1, 2'b00, a, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    push(tag, S_RD, v);
    push({tag, "_ill"}, S_ILL, 32'h0);
    check();
  endtask

  task automatic wr(input string tag, input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd, input logic [31:0] old);
    drive(1'b1, op, a, wd, 1'b0, 1'b0, 1'b0, 32'h0);
    push(tag, S_RD, old);
    check();
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; csr_en = 1'b0; csr_op = 2'b00; ecall = 1'b0; mret = 1'b0; instr_retire = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    do_reset();
    drive(1'b0, 2'b00, 12'h300, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    push("rst_mtvec", S_MTVEC, 32'h0);
    push("rst_mepc", S_MEPC, 32'h0);
    push("rst_redirect", S_RED, 32'h0);
    check();
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rd("rst_mtvec_rd", 12'h305, 32'h0);
    rd("rst_mscratch", 12'h340, 32'h0);
    wr("mtvec_rw", 2'b01, 12'h305, 32'h8000_0103, 32'h0);
    rd("mtvec_align", 12'h305, 32'h8000_0100);
    push("mtvec_port", S_MTVEC, 32'h8000_0100);
    check();
    wr("mscr_rw", 2'b01, 12'h340, 32'h0000_000F, 32'h0);
    wr("mscr_rs", 2'b10, 12'h340, 32'h0000_00F0, 32'h0000_000F);
    rd("mscr_rs_rd", 12'h340, 32'h0000_00FF);
    wr("mscr_rc", 2'b11, 12'h340, 32'h0000_000F, 32'h0000_00FF);
    rd("mscr_rc_rd", 12'h340, 32'h0000_00F0);
    wr("mscr_op00", 2'b00, 12'h340, 32'hFFFF_FFFF, 32'h0000_00F0);
    rd("mscr_op00_rd", 12'h340, 32'h0000_00F0);
    wr("mstatus_rs", 2'b10, 12'h300, 32'h0000_0008, 32'h0000_1800);
    rd("mstatus_mie", 12'h300, 32'h0000_1808);
    drive(1'b0, 2'b00, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8000_0044);
    push("ecall_redirect", S_RED, 32'h8000_0100);
    check();
    rd("ecall_mepc", 12'h341, 32'h8000_0044);
    push("ecall_mepc_port", S_MEPC, 32'h8000_0044);
    check();
    rd("ecall_mcause", 12'h342, 32'd11);
    rd("ecall_mstatus", 12'h300, 32'h0000_1880);
    drive(1'b0, 2'b00, 12'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    push("mret_redirect", S_RED, 32'h8000_0044);
    check();
    rd("mret_mstatus", 12'h300, 32'h0000_1888);
    drive(1'b1, 2'b01, 12'h341, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 32'h8000_0088);
    push("ecall_wr_old", S_RD, 32'h8000_0044);
    push("ecall_wr_redirect", S_RED, 32'h8000_0100);
    check();
    rd("ecall_wr_dropped", 12'h341, 32'h8000_0088);
    rd("ecall2_mstatus", 12'h300, 32'h0000_1880);
    drive(1'b0, 2'b00, 12'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h8000_00C0);
    push("both_redirect", S_RED, 32'h8000_0100);
    check();
    rd("both_mstatus", 12'h300, 32'h0000_1800);
    rd("both_mepc", 12'h341, 32'h8000_00C0);
    drive(1'b1, 2'b01, 12'h7C0, 32'h0000_DEAD, 1'b0, 1'b0, 1'b0, 32'h0);
    push("illegal_flag", S_ILL, 32'h1);
    push("illegal_rdata", S_RD, 32'h0);
    check();
    rd("illegal_nochg_mscr", 12'h340, 32'h0000_00F0);
    rd("illegal_nochg_mtvec", 12'h305, 32'h8000_0100);
    wr("mepc_rw", 2'b01, 12'h341, 32'h0000_0013, 32'h8000_00C0);
    rd("mepc_align", 12'h341, 32'h0000_0010);
    wr("mcause_rw", 2'b01, 12'h342, 32'hFFFF_FFFF, 32'd11);
    rd("mcause_full", 12'h342, 32'hFFFF_FFFF);
`ifdef YSYX_23060061_CSR_COUNTERS_EN
    do_reset();
    rd("mcycle_first", 12'hB00, 32'h0);
    rd("mcycle_second", 12'hB00, 32'h1);
    wr("mcycle_rw", 2'b01, 12'hB00, 32'hFFFF_FFFF, 32'h2);
    rd("mcycle_written", 12'hB00, 32'hFFFF_FFFF);
    rd("mcycleh_carry", 12'hB80, 32'h1);
    rd("mcycle_wrapped", 12'hB00, 32'h1);
    wr("mcycle_rw2", 2'b01, 12'hB00, 32'hFFFF_FFFF, 32'h2);
    wr("mcycleh_rw", 2'b01, 12'hB80, 32'h0000_0055, 32'h1);
    rd("mcycleh_kept", 12'hB80, 32'h0000_0055);
    rd("mcycle_after_wrap", 12'hB00, 32'h1);
    repeat (5) drive(1'b0, 2'b00, 12'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    rd("minstret_5", 12'hB02, 32'h5);
    rd("minstreth_0", 12'hB82, 32'h0);
    drive(1'b1, 2'b01, 12'hB02, 32'h0000_0100, 1'b0, 1'b0, 1'b1, 32'h0);
    push("minstret_rw_old", S_RD, 32'h5);
    check();
    rd("minstret_wr_wins", 12'hB02, 32'h0000_0100);
    do_reset();
    rd("mcycle_rst_mid", 12'hB00, 32'h0);
    rd("minstret_rst_mid", 12'hB02, 32'h0);
`else
    drive(1'b1, 2'b00, 12'hB00, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    push("nocnt_mcycle_ill", S_ILL, 32'h1);
    push("nocnt_mcycle_rd", S_RD, 32'h0);
    check();
    drive(1'b1, 2'b01, 12'hB82, 32'h1, 1'b0, 1'b0, 1'b1, 32'h0);
    push("nocnt_minstreth_ill", S_ILL, 32'h1);
    check();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
